// File: rtl/hes_stream_ctrl.sv
// Byte-stream XOR cipher controller: one output register stage, keystream byte
// taken from a shared external S-box indexed by (key + byte index).
module hes_stream_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] key,
  input  logic [8:0] msg_len,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [7:0] sbox_addr,
  input  logic [7:0] sbox_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] byte_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_key;
  logic [8:0] r_len;
  logic [8:0] r_idx;
  logic [8:0] r_cnt;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic       r_out_last;
  logic       r_err;

  logic w_in_hs;
  logic w_out_hs;
  logic w_last_in;

  // rst gates in_ready combinationally so no byte is taken in the reset cycle
  assign in_ready   = !rst && (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_last_in  = (r_idx == (r_len - 9'd1));

  assign sbox_addr  = r_key + r_idx[7:0];
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign byte_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_key       <= 8'd0;
      r_len       <= 9'd0;
      r_idx       <= 9'd0;
      r_cnt       <= 9'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= key;
            r_len   <= msg_len;
            r_idx   <= 9'd0;
            r_cnt   <= 9'd0;
            r_state <= (msg_len == 9'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end else begin
            // a new byte overwrites the register even while the old one leaves
            if (w_in_hs) begin
              r_out_data  <= in_data ^ sbox_data;
              r_out_valid <= 1'b1;
              r_out_last  <= w_last_in;
              r_idx       <= r_idx + 9'd1;
              r_cnt       <= r_cnt + 9'd1;
              if (w_last_in) r_state <= S_DRAIN;
            end else if (w_out_hs) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
            if ((r_state == S_DRAIN) && w_out_hs && r_out_last) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hes_stream_ctrl.sv
// Bench for hes_stream_ctrl: AES S-box environment, vector table, directed
// corner sequences and a randomized queue-based reference model.
module tb_hes_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, out_ready;
  logic [7:0] key, in_data, sbox_data, sbox_addr, out_data;
  logic [8:0] msg_len, byte_count;
  logic       in_ready, out_valid, out_last, busy, done, err;

  logic [7:0] sbox_tab [256];
  int checks = 0;
  int failures = 0;

  // expected-output model: queue of {last, data}, plus message bookkeeping
  logic [7:0] m_key;
  int         m_len, m_sent, m_got;
  logic [8:0] m_q [$];

  typedef struct {
    logic [7:0] key;
    logic [7:0] din;
    logic [7:0] addr;
    logic [7:0] dout;
  } vec_t;
  vec_t vt [6];

  hes_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .msg_len(msg_len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .busy(busy), .done(done), .err(err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;
  assign sbox_data = sbox_tab[sbox_addr];

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'd0;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(v), 8'(x)) == 8'd1) inv = 8'(x);
      sbox_tab[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic start_msg(input logic [7:0] k, input int len);
    start = 1'b1; key = k; msg_len = 9'(len);
    m_key = k; m_len = len; m_sent = 0; m_got = 0; m_q.delete();
    step();
    start = 1'b0; key = ~k; msg_len = 9'($urandom);
    chk("start_busy", busy, 1);
    chk("start_count", byte_count, 0);
    chk("start_err", err, 0);
  endtask

  // One cycle of traffic checked against the queue model.
  task automatic drive_cycle(input bit iv, input bit ordy);
    logic [8:0] e;
    logic [7:0] a, hd;
    logic hs_in, hs_out, fin, stalled, hl;
    in_valid = iv; in_data = 8'($urandom); out_ready = ordy;
    #1;
    a = m_key + 8'(m_sent);
    chk("busy", busy, 1);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("in_ready", in_ready, (m_sent < m_len) && (m_q.size() == 0 || ordy));
    chk("sbox_addr", sbox_addr, a);
    hs_in = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    fin = 1'b0;
    if (hs_out && m_q.size() != 0) begin
      e = m_q.pop_front();
      chk("out_data", out_data, e[7:0]);
      chk("out_last", out_last, e[8]);
      fin = e[8];
      m_got++;
    end
    if (hs_in) begin
      m_q.push_back({1'(m_sent == m_len - 1), in_data ^ sbox_tab[a]});
      m_sent++;
    end
    stalled = out_valid && !out_ready;
    hd = out_data; hl = out_last;
    step();
    chk("done", done, fin);
    chk("byte_count", byte_count, m_sent);
    if (stalled) begin
      chk("stall_data", out_data, hd);
      chk("stall_last", out_last, hl);
    end
  endtask

  task automatic run_rest(input int vpct, input int rpct);
    int cyc = 0;
    while (m_got < m_len && cyc < 4000) begin
      drive_cycle(int'($urandom_range(99)) < vpct, int'($urandom_range(99)) < rpct);
      cyc++;
    end
    in_valid = 1'b0;
    if (m_got < m_len) begin
      checks++; failures++;
      $display("FAIL timeout got=%0d expected=%0d", m_got, m_len);
      do_reset();
    end else begin
      step();
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("final_count", byte_count, m_len);
    end
  endtask

  initial begin
    vt[0] = '{8'h00, 8'h00, 8'h00, 8'h63};
    vt[1] = '{8'h01, 8'h00, 8'h01, 8'h7c};
    vt[2] = '{8'h53, 8'h00, 8'h53, 8'hed};
    vt[3] = '{8'hff, 8'hff, 8'hff, 8'he9};
    vt[4] = '{8'h10, 8'haa, 8'h10, 8'h60};
    vt[5] = '{8'hfe, 8'h0f, 8'hfe, 8'hb4};
    key = 8'h5a; msg_len = 9'd7; in_data = 8'h00;
    build_sbox();
    rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_addr", sbox_addr, 0);
    do_reset();
    step();

    // single-byte vectors
    for (int i = 0; i < 6; i++) begin
      start_msg(vt[i].key, 1);
      in_valid = 1'b1; in_data = vt[i].din; out_ready = 1'b1;
      #1;
      chk("vec_addr", sbox_addr, vt[i].addr);
      chk("vec_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_out_data", out_data, vt[i].dout);
      chk("vec_out_last", out_last, 1);
      chk("vec_drain_ready", in_ready, 0);
      step();
      chk("vec_done", done, 1);
      chk("vec_out_clear", out_valid, 0);
      step();
      chk("vec_done_pulse", done, 0);
      chk("vec_idle", busy, 0);
    end

    // key 0xFE wraps through 0xFF to 0x00
    begin
      logic [7:0] din [3], addr [3], dout [3];
      din  = '{8'h11, 8'h22, 8'h33};
      addr = '{8'hfe, 8'hff, 8'h00};
      dout = '{8'haa, 8'h34, 8'h50};
      start_msg(8'hfe, 3);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1; in_data = din[i];
        #1;
        chk("wrap_addr", sbox_addr, addr[i]);
        step();
        chk("wrap_data", out_data, dout[i]);
        chk("wrap_last", out_last, i == 2);
      end
      in_valid = 1'b0;
      chk("wrap_count", byte_count, 3);
      step();
      chk("wrap_done", done, 1);
      step();
    end

    // backpressure for 3 cycles after the first output
    start_msg(8'h3c, 4);
    drive_cycle(1, 1);
    repeat (3) drive_cycle(1, 0);
    run_rest(100, 100);

    // zero-length message
    start_msg(8'h77, 0);
    chk("len0_done", done, 1);
    chk("len0_valid", out_valid, 0);
    chk("len0_in_ready", in_ready, 0);
    step();
    chk("len0_done_pulse", done, 0);
    chk("len0_busy", busy, 0);

    // start while busy, with changed key/len that must be ignored
    start_msg(8'h21, 5);
    drive_cycle(1, 1);
    start = 1'b1; key = 8'h99; msg_len = 9'd7;
    drive_cycle(1, 1);
    start = 1'b0;
    chk("err_pulse", err, 1);
    drive_cycle(1, 1);
    chk("err_clear", err, 0);
    run_rest(80, 80);

    // abort after 2 of 5 bytes, competing with both handshakes
    start_msg(8'h42, 5);
    drive_cycle(1, 1);
    drive_cycle(1, 1);
    abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_done", done, 0);
    chk("abort_count", byte_count, 2);
    step();
    chk("abort_no_done", done, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_count", byte_count, 2);
    start_msg(8'h42, 5);
    run_rest(90, 90);

    // reset mid-message
    start_msg(8'h13, 5);
    drive_cycle(1, 1);
    drive_cycle(1, 1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", byte_count, 0);
    chk("rst_mid_addr", sbox_addr, 0);
    step();
    chk("rst_mid_done", done, 0);
    chk("rst_mid_in_ready2", in_ready, 0);
    in_valid = 1'b0;

    // randomized messages, including a full 256-byte one
    for (int m = 0; m < 25; m++) begin
      start_msg(8'($urandom), (m == 0) ? 256 : int'($urandom_range(12, 1)));
      run_rest(int'($urandom_range(95, 40)), int'($urandom_range(95, 40)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
